// File: rtl/beat_pkg.sv
// Shared types and helpers for the beat bus decoder.
// Beat k is encoded as T == 1 << (NBEAT-1-k); beat 0 is the MSB.
package beat_pkg;

  localparam int unsigned NBEAT_DEF = 4;
  // Helpers operate on a fixed maximum width; callers zero-extend.
  localparam int unsigned BEAT_MAX  = 32;

  typedef enum logic [0:0] {SYNC, TRACK} beat_state_e;

  // Legal successor of an n-bit beat vector: {t[0], t[n-1:1]}.
  function automatic logic [BEAT_MAX-1:0] rot_beat(input logic [BEAT_MAX-1:0] t,
                                                   input int unsigned n);
    logic [BEAT_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BEAT_MAX; i++) begin
      if (i + 1 < n) begin
        r[i] = t[(i + 1) % BEAT_MAX];
      end else if (i + 1 == n) begin
        r[i] = t[0];
      end
    end
    return r;
  endfunction

  // One-hot to beat index; only meaningful when t is one-hot.
  function automatic int unsigned beat_to_idx(input logic [BEAT_MAX-1:0] t,
                                              input int unsigned n);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < BEAT_MAX; i++) begin
      if (i < n && t[i]) begin
        idx = idx | (n - 1 - i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/beat_onehot_chk.sv
// Combinational classification of the sampled beat vector against the
// previous sample: one-hot, beat-0 pattern, legal successor, and index.
module beat_onehot_chk
  import beat_pkg::*;
#(
  parameter int unsigned NBEAT = NBEAT_DEF
) (
  input  logic [NBEAT-1:0]         T,
  input  logic [NBEAT-1:0]         prev_T,
  output logic                     is_onehot,
  output logic                     is_first,
  output logic                     is_succ,
  output logic [$clog2(NBEAT)-1:0] idx
);

  localparam int unsigned IW = $clog2(NBEAT);

  logic [BEAT_MAX-1:0] t_ext;
  logic [BEAT_MAX-1:0] prev_ext;
  logic [BEAT_MAX-1:0] succ;

  assign t_ext    = BEAT_MAX'(T);
  assign prev_ext = BEAT_MAX'(prev_T);
  assign succ     = rot_beat(prev_ext, NBEAT);

  assign is_onehot = (T != '0) && ((T & (T - NBEAT'(1))) == '0);
  assign is_first  = (T == {1'b1, {(NBEAT-1){1'b0}}});
  // A zero prev_T rotates to zero, so one-hot-ness of T must be required too.
  assign is_succ   = is_onehot && (t_ext == succ);
  assign idx       = IW'(beat_to_idx(t_ext, NBEAT));

endmodule

// File: rtl/beat_decoder.sv
// Consumer of the one-hot beat bus: lock/track FSM, beat index, cycle counter,
// sticky error. Optional saturating error counter via BEAT_ERR_CNT_EN.
module beat_decoder
  import beat_pkg::*;
#(
  parameter int unsigned NBEAT = NBEAT_DEF,
  parameter int unsigned CYC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NBEAT-1:0]         T,
  input  logic                     clr_err,
  output logic                     beat_vld,
  output logic [$clog2(NBEAT)-1:0] beat_idx,
  output logic                     cyc_start,
  output logic                     cyc_done,
  output logic [CYC_W-1:0]         cyc_cnt,
`ifdef BEAT_ERR_CNT_EN
  output logic [7:0]               err_cnt,
`endif
  output logic                     err
);

  localparam int unsigned IW = $clog2(NBEAT);

  beat_state_e      state_q, state_d;
  logic [NBEAT-1:0] prev_t_q;
  logic             vld_q, vld_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             err_set;

  logic          is_onehot;
  logic          is_first;
  logic          is_succ;
  logic [IW-1:0] cur_idx;

  beat_onehot_chk #(
    .NBEAT(NBEAT)
  ) u_chk (
    .T        (T),
    .prev_T   (prev_t_q),
    .is_onehot(is_onehot),
    .is_first (is_first),
    .is_succ  (is_succ),
    .idx      (cur_idx)
  );

  always_comb begin
    state_d = state_q;
    vld_d   = 1'b0;
    idx_d   = '0;
    start_d = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (is_first) begin
          state_d = TRACK;
          vld_d   = 1'b1;
          start_d = 1'b1;
        end
      end
      TRACK: begin
        if (is_succ) begin
          vld_d   = 1'b1;
          idx_d   = cur_idx;
          start_d = is_first;
          if (cur_idx == IW'(NBEAT - 1)) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end else begin
          // A mismatching beat-0 pattern is dropped; relock needs a fresh sample.
          state_d = SYNC;
          err_set = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
    // Set has priority over clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SYNC;
      prev_t_q <= '0;
      vld_q    <= 1'b0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_t_q <= T;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign beat_vld  = vld_q;
  assign beat_idx  = idx_q;
  assign cyc_start = start_q;
  assign cyc_done  = done_q;
  assign cyc_cnt   = cnt_q;
  assign err       = err_q;

`ifdef BEAT_ERR_CNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (err_set) begin
      if (clr_err) begin
        ecnt_d = 8'd1;
      end else if (ecnt_q != 8'hff) begin
        ecnt_d = ecnt_q + 8'd1;
      end
    end else if (clr_err) begin
      ecnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_cnt = ecnt_q;
`else
  // Without the counter, err alone records sequence corruption.
`endif

endmodule
